// File: rtl/eq_mixer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// eq_mixer_pkg : shared widths, PCM limits and mixer FSM states
// Rev 1.0
// ------------------------------------------------------------------
package eq_mixer_pkg;

  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int BAND_W    = 48;
  localparam int PCM_W     = 24;

  localparam logic [GAIN_W-1:0]       UNITY_GAIN = 16'h4000;
  localparam logic signed [PCM_W-1:0] PCM_MAX    = 24'sh7FFFFF;
  localparam logic signed [PCM_W-1:0] PCM_MIN    = 24'sh800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RND  = 2'd2
  } mix_state_t;

endpackage
`default_nettype wire

// File: rtl/eq_round_sat.sv
`default_nettype none
// ------------------------------------------------------------------
// eq_round_sat : round-half-up, arithmetic shift and 24-bit saturation
// Rev 1.0
// ------------------------------------------------------------------
module eq_round_sat
  import eq_mixer_pkg::*;
#(
  parameter int ACC_W = 66,
  parameter int SHIFT = 29
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [PCM_W-1:0] pcm_o,
  output logic                    clip_o
);

  // One guard bit so adding the half-LSB can never wrap the accumulator.
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(1) <<< (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(PCM_MAX);
  localparam logic signed [SUM_W-1:0] MIN_EXT = SUM_W'(PCM_MIN);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] res;

  assign sum = SUM_W'(acc_i) + HALF;
  assign res = sum >>> SHIFT;

  always_comb begin
    pcm_o  = res[PCM_W-1:0];
    clip_o = 1'b0;
    if (res > MAX_EXT) begin
      pcm_o  = PCM_MAX;
      clip_o = 1'b1;
    end else if (res < MIN_EXT) begin
      pcm_o  = PCM_MIN;
      clip_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eq_band_mixer.sv
`default_nettype none
// ------------------------------------------------------------------
// eq_band_mixer : per-band gain, time-multiplexed MAC and PCM rounding
// Rev 1.0
// ------------------------------------------------------------------
module eq_band_mixer
  import eq_mixer_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int IN_SHIFT  = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          audio_en,
  input  logic                          gain_wr_en,
  input  logic [$clog2(NUM_BANDS)-1:0]  gain_wr_addr,
  input  logic [GAIN_W-1:0]             gain_wr_data,
  input  logic [BAND_W*NUM_BANDS-1:0]   l_audio_in,
  input  logic [BAND_W*NUM_BANDS-1:0]   r_audio_in,
  input  logic                          l_in_valid,
  input  logic                          r_in_valid,
  input  logic                          flag_clr,
  output logic [PCM_W-1:0]              l_pcm_out,
  output logic [PCM_W-1:0]              r_pcm_out,
  output logic                          l_out_valid,
  output logic                          r_out_valid,
  output logic                          busy,
  output logic                          sat_flag,
  output logic                          overrun_flag
);

  localparam int AW     = $clog2(NUM_BANDS);
  localparam int PROD_W = BAND_W + GAIN_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam int VEC_W  = BAND_W * NUM_BANDS;
  localparam logic [AW-1:0] LAST_BAND = AW'(NUM_BANDS - 1);

  mix_state_t              state_q;
  logic                    sel_q, sel_d, start_d;   // sel: 0 = left, 1 = right
  logic                    pend_l_q, pend_r_q, pend_l_eff, pend_r_eff;
  logic [VEC_W-1:0]        l_shad_q, r_shad_q, work_q, work_d;
  logic [AW-1:0]           band_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [GAIN_W-1:0]       gain_stg_q [NUM_BANDS];
  logic [GAIN_W-1:0]       gain_act_q [NUM_BANDS];
  logic signed [PROD_W-1:0] prod;
  logic signed [PCM_W-1:0] rnd_pcm;
  logic                    rnd_clip, sat_set, overrun_set;
  logic [PCM_W-1:0]        l_pcm_q, r_pcm_q;
  logic                    l_vld_q, r_vld_q, sat_q, ovr_q;

  // An arriving strobe counts as pending in the same cycle, so a channel can start immediately.
  assign pend_l_eff  = pend_l_q | l_in_valid;
  assign pend_r_eff  = pend_r_q | r_in_valid;
  assign overrun_set = (l_in_valid & pend_l_q) | (r_in_valid & pend_r_q);
  assign sat_set     = (state_q == RND) & rnd_clip;

  always_comb begin
    start_d = 1'b0;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pend_l_eff) begin
          start_d = 1'b1;
          sel_d   = 1'b0;
        end else if (pend_r_eff) begin
          start_d = 1'b1;
          sel_d   = 1'b1;
        end
      end
      RND: begin
        if (!sel_q && pend_r_eff) begin
          start_d = 1'b1;
          sel_d   = 1'b1;
        end else if (sel_q && pend_l_eff) begin
          start_d = 1'b1;
          sel_d   = 1'b0;
        end
      end
      default: ;
    endcase
    if (sel_d) work_d = r_in_valid ? r_audio_in : r_shad_q;
    else       work_d = l_in_valid ? l_audio_in : l_shad_q;
  end

  assign prod = PROD_W'($signed(work_q[band_q*BAND_W +: BAND_W])) *
                PROD_W'($signed(gain_act_q[band_q]));

  eq_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (IN_SHIFT + GAIN_FRAC)
  ) u_round_sat (
    .acc_i  (acc_q),
    .pcm_o  (rnd_pcm),
    .clip_o (rnd_clip)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || !audio_en) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      band_q   <= '0;
      acc_q    <= '0;
      l_pcm_q  <= '0;
      r_pcm_q  <= '0;
      l_vld_q  <= 1'b0;
      r_vld_q  <= 1'b0;
      sat_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      l_vld_q  <= 1'b0;
      r_vld_q  <= 1'b0;
      sat_q    <= sat_set | (sat_q & ~flag_clr);
      ovr_q    <= overrun_set | (ovr_q & ~flag_clr);
      if (l_in_valid) l_shad_q <= l_audio_in;
      if (r_in_valid) r_shad_q <= r_audio_in;
      pend_l_q <= pend_l_eff & ~(start_d & ~sel_d);
      pend_r_q <= pend_r_eff & ~(start_d & sel_d);
      case (state_q)
        ACC: begin
          acc_q  <= acc_q + ACC_W'(prod);
          band_q <= band_q + 1'b1;
          if (band_q == LAST_BAND) state_q <= RND;
        end
        RND: begin
          if (sel_q) begin
            r_pcm_q <= rnd_pcm;
            r_vld_q <= 1'b1;
          end else begin
            l_pcm_q <= rnd_pcm;
            l_vld_q <= 1'b1;
          end
          if (!start_d) state_q <= IDLE;
        end
        default: ;
      endcase
      if (start_d) begin
        state_q <= ACC;
        sel_q   <= sel_d;
        work_q  <= work_d;
        acc_q   <= '0;
        band_q  <= '0;
      end
    end
  end

  // Gains survive audio_en flushes; only reset_n restores unity.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        gain_stg_q[k] <= UNITY_GAIN;
        gain_act_q[k] <= UNITY_GAIN;
      end
    end else begin
      if (gain_wr_en && (int'(gain_wr_addr) < NUM_BANDS))
        gain_stg_q[gain_wr_addr] <= gain_wr_data;
      if (audio_en && start_d)
        gain_act_q <= gain_stg_q;
    end
  end

  assign l_pcm_out    = l_pcm_q;
  assign r_pcm_out    = r_pcm_q;
  assign l_out_valid  = l_vld_q;
  assign r_out_valid  = r_vld_q;
  assign busy         = (state_q != IDLE);
  assign sat_flag     = sat_q;
  assign overrun_flag = ovr_q;

endmodule
`default_nettype wire

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
- Downstream stage of the FIR equalizer filter bank. Consumes the per-band 48-bit L/R filter outputs and their valid strobes.
- Applies a programmable signed gain to each band and sums the bands through one time-multiplexed multiply-accumulator. Rounds and saturates the sum to 24-bit PCM for the output/I2S stage.
- Per-band gains are written by the host control path, in the same style as coefficient writes.

Parameters:
- NUM_BANDS, 4, number of filter bands; must equal the filter bank's filter count, 2..16.
- IN_SHIFT, 15, fractional bits of the band inputs: PCM-scale value = band_in >>> IN_SHIFT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- audio_en  in  1  low = flush datapath, FSM and outputs; gains retained
- gain_wr_en  in  1  strobe: write gain_wr_data to staging gain[gain_wr_addr]
- gain_wr_addr  in  clog2(NUM_BANDS)  band index
- gain_wr_data  in  16  signed Q2.14 gain; 0x4000 = unity
- l_audio_in  in  48 x NUM_BANDS  signed left band samples
- r_audio_in  in  48 x NUM_BANDS  signed right band samples
- l_in_valid  in  1  strobe: l_audio_in valid this cycle
- r_in_valid  in  1  strobe: r_audio_in valid this cycle
- flag_clr  in  1  clears sat_flag and overrun_flag
- l_pcm_out  out  24  signed left mixed PCM, held until next update
- r_pcm_out  out  24  signed right mixed PCM
- l_out_valid  out  1  one-cycle strobe: l_pcm_out updated
- r_out_valid  out  1  one-cycle strobe: r_pcm_out updated
- busy  out  1  FSM not in IDLE
- sat_flag  out  1  sticky: any output clipped
- overrun_flag  out  1  sticky: pending channel input overwritten

Behaviour:
- Reset (reset_n low at clk edge):
  - All outputs 0, FSM to IDLE, pending bits cleared.
  - Staging and active gains all 0x4000.
  - A reset mid-accumulation abandons the sample and produces no strobe.
- audio_en low: same as reset, except both gain banks keep their values.
- Input capture: on x_in_valid, the x band vector is latched into a shadow register and pend_x is set.
  - If pend_x is already set (capture not yet started), the new data overwrites it and overrun_flag is set.
  - Capture is allowed while the other channel is accumulating.
- FSM states IDLE, ACC, RND.
  - IDLE: if pend_l, select L; else if pend_r, select R; go to ACC. L has priority on simultaneous arrival.
  - On ACC entry: clear pend for the selected channel, copy staging gains to active gains, set acc = 0, set band = 0.
  - ACC: acc += shadow[band] * active_gain[band] (48x16 signed, product 64 bits, acc 64+clog2(NUM_BANDS) bits). band increments each cycle; after band NUM_BANDS-1, go to RND.
  - RND:
    - res = (acc + 2^(S-1)) >>> S, where S = IN_SHIFT+14. This is round-half-up, arithmetic shift.
    - Saturate res to [-0x800000, 0x7FFFFF]; on clip, set sat_flag.
    - Register the result to x_pcm_out and pulse x_out_valid the next cycle.
    - Next state: ACC directly if the other channel is pending (same entry actions), else IDLE.
- Latency from idle:
  - x_in_valid at cycle 0 -> ACC cycles 1..N -> RND cycle N+1 -> x_out_valid high at cycle N+2.
  - With simultaneous L/R: L strobe at N+2, R strobe at 2N+3.
- Throughput: 2N+2 cycles per stereo frame must not exceed the sample period; exceeding it raises overrun_flag.
- Gain writes go to the staging bank only and take effect at the next ACC entry. An accumulation in progress always uses one consistent gain set.
- flag_clr clears both flags; a set event in the same cycle wins.
- Out-of-range gain_wr_addr (>= NUM_BANDS) is ignored.

Decomposition:
- Package eq_mixer_pkg:
  - GAIN_W=16, GAIN_FRAC=14, BAND_W=48, PCM_W=24, UNITY_GAIN=16'h4000
  - PCM_MAX, PCM_MIN
  - typedef enum {IDLE, ACC, RND} mix_state_t
- Sub-module eq_round_sat: parameterised acc width and shift; performs round, shift and saturate; outputs a 24-bit result and a clip bit.
- MAC, FSM and gain banks stay in eq_band_mixer.

Test Plan (NUM_BANDS=4, IN_SHIFT=15):
- Unity pass: band0 = 1000<<15, others 0, default gains, l_in_valid at cycle 0 -> l_pcm_out = 1000, l_out_valid exactly at cycle 6, sat_flag 0.
- Saturation: all four L bands = 0x7FFFFF<<15, unity -> l_pcm_out = 0x7FFFFF, sat_flag 1. All bands = -0x800000<<15 -> 0x800000. flag_clr -> sat_flag 0.
- Rounding: band0 = -49152 (-1.5), unity -> l_pcm_out = 0xFFFFFF (-1). band0 = 49152 -> 2.
- Simultaneous L/R: both strobes at cycle 0, L band0 = 100<<15, R band0 = 200<<15 -> l_out_valid cycle 6 = 100, r_out_valid cycle 11 = 200.
- Gain staging: write gain0 = 0x2000 at cycle 2 during L ACC -> L = 1000 (old gain), pending R with band0 = 1000<<15 -> 500.
- Overrun/reset: two l_in_valid 2 cycles apart while R accumulates -> overrun_flag 1, output uses the second vector. reset_n low at cycle 3 of ACC -> no strobe, outputs 0, gains 0x4000.
